// File: rtl/pipe_event_counter.sv
// Performance-event counter for the pipelined core: counts cycles, filtered stalls,
// IF/ID flushes and retired instructions over a bounded run window, read through a registered port.
module pipe_event_counter #(
   parameter int WIDTH      = 32,
   parameter int MAX_CYCLES = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic             clear_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             done_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] cyc_q, cyc_d;
   logic [WIDTH-1:0] stall_q, stall_d;
   logic [WIDTH-1:0] flush_q, flush_d;
   logic [WIDTH-1:0] retire_q, retire_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             count_en;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v, input logic en);
      if (en && (v != {WIDTH{1'b1}}))
         return v + WIDTH'(1);
      return v;
   endfunction

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      stall_d    = stall_q;
      flush_d    = flush_q;
      retire_d   = retire_q;
      rd_valid_d = rd_req_i;
      rd_data_d  = rd_data_q;
      count_en   = 1'b0;

      case (state_q)
         IDLE:    count_en = start_i;
         RUN:     count_en = start_i;
         DONE:    count_en = 1'b0;
         default: state_d  = IDLE;
      endcase

      if (count_en) begin
         cyc_d    = sat_inc(cyc_q, 1'b1);
         stall_d  = sat_inc(stall_q, stall_i && !branch_i);
         flush_d  = sat_inc(flush_q, flush_i);
         retire_d = sat_inc(retire_q, retire_i);
         state_d  = RUN;
         // The window closes on the edge that brings the cycle count to MAX_CYCLES.
         if ((MAX_CYCLES != 0) && (64'(cyc_d) == 64'(MAX_CYCLES)))
            state_d = DONE;
      end

      if (clear_i) begin
         state_d  = IDLE;
         cyc_d    = '0;
         stall_d  = '0;
         flush_d  = '0;
         retire_d = '0;
      end

      // Reads see the counters as they were before this edge's update or clear.
      if (rd_req_i) begin
         case (rd_sel_i)
            2'd0:    rd_data_d = cyc_q;
            2'd1:    rd_data_d = stall_q;
            2'd2:    rd_data_d = flush_q;
            default: rd_data_d = retire_q;
         endcase
      end

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         cyc_q      <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
         retire_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         cyc_q      <= cyc_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
         retire_q   <= retire_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign done_o     = done_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_pipe_event_counter.sv
// Bench for pipe_event_counter: a 32-bit/64-cycle instance checked against a counting model,
// plus a 4-bit unbounded instance for saturation.
module tb_pipe_event_counter;

   localparam longint MAXC = 64;
   localparam longint MAXV = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0, retire = 1'b0;
   logic        clear = 1'b0, rd_req = 1'b0;
   logic [1:0]  rd_sel = 2'd0;

   logic        rd_valid, done;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic        s_rd_valid, s_done;
   logic [3:0]  s_rd_data;
   logic [1:0]  s_state;

   int checks = 0;
   int failures = 0;

   longint m_cnt[4];
   int     m_state = 0;
   logic   m_valid = 1'b0;
   longint m_data = 0;

   always #5 clk = ~clk;

   pipe_event_counter #(.WIDTH(32), .MAX_CYCLES(64)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .rd_req_i(rd_req),
      .rd_sel_i(rd_sel), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .done_o(done), .state_o(state)
   );

   pipe_event_counter #(.WIDTH(4), .MAX_CYCLES(0)) dut_sat (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .rd_req_i(rd_req),
      .rd_sel_i(rd_sel), .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
      .done_o(s_done), .state_o(s_state)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_state = 0;
      m_valid = 1'b0;
      m_data  = 0;
   endtask

   // Predict one edge from the applied inputs, take the edge, compare the main instance.
   task automatic cycle();
      m_valid = rd_req;
      if (rd_req) m_data = m_cnt[rd_sel];
      if (clear) begin
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_state = 0;
      end else if (m_state != 2 && start) begin
         m_cnt[0] = sat(m_cnt[0] + 1);
         if (stall && !branch) m_cnt[1] = sat(m_cnt[1] + 1);
         if (flush)  m_cnt[2] = sat(m_cnt[2] + 1);
         if (retire) m_cnt[3] = sat(m_cnt[3] + 1);
         m_state = (m_cnt[0] == MAXC) ? 2 : 1;
      end
      @(posedge clk);
      #1;
      chk("state", 64'(state), 64'(m_state));
      chk("done", 64'(done), 64'(m_state == 2));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_data", 64'(rd_data), 64'(m_data));
   endtask

   task automatic idle_inputs();
      start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0; retire = 1'b0;
      clear = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      model_reset();
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 64'(state), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_valid", 64'(rd_valid), 0);
      chk("rst_data", 64'(rd_data), 0);
      rst = 1'b1;

      // Basic count up to the window limit, then frozen
      start = 1'b1;
      repeat (64) cycle();
      chk("basic_state_done", 64'(state), 2);
      chk("basic_done", 64'(done), 1);
      repeat (10) cycle();
      rd_req = 1'b1;
      for (int s = 0; s < 4; s++) begin
         rd_sel = 2'(s);
         cycle();
      end
      rd_req = 1'b0;
      cycle();
      rd_req = 1'b1; rd_sel = 2'd0;
      cycle();
      chk("basic_cycle64", 64'(rd_data), 64);

      // Clear from DONE with a simultaneous read
      clear = 1'b1;
      cycle();
      chk("clr_preval", 64'(rd_data), 64);
      chk("clr_state", 64'(state), 0);
      chk("clr_done", 64'(done), 0);
      clear = 1'b0;
      start = 1'b0;
      for (int s = 0; s < 4; s++) begin
         rd_sel = 2'(s);
         cycle();
         chk("clr_zero", 64'(rd_data), 0);
      end
      rd_req = 1'b0;

      // Stall filtering with flush/retire pulses
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         stall  = 1'b1;
         branch = (i >= 5);
         flush  = (i < 4);
         retire = (i < 7);
         cycle();
      end
      idle_inputs();
      rd_req = 1'b1;
      rd_sel = 2'd1; cycle(); chk("filt_stall", 64'(rd_data), 5);
      rd_sel = 2'd2; cycle(); chk("filt_flush", 64'(rd_data), 4);
      rd_sel = 2'd3; cycle(); chk("filt_retire", 64'(rd_data), 7);
      chk("filt_valid", 64'(rd_valid), 1);

      // Back-to-back reads of the cycle counter while counting
      start = 1'b1; rd_sel = 2'd0;
      repeat (6) cycle();
      idle_inputs();
      cycle();

      // Randomized traffic against the model
      clear = 1'b1;
      cycle();
      for (int i = 0; i < 300; i++) begin
         start  = ($urandom_range(0, 9) != 0);
         stall  = $urandom_range(0, 1);
         branch = $urandom_range(0, 1);
         flush  = ($urandom_range(0, 3) == 0);
         retire = $urandom_range(0, 1);
         clear  = ($urandom_range(0, 59) == 0);
         rd_req = $urandom_range(0, 1);
         rd_sel = 2'($urandom_range(0, 3));
         cycle();
      end

      // Asynchronous reset between edges
      idle_inputs();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      start = 1'b1; retire = 1'b1; stall = 1'b1;
      repeat (5) cycle();
      rd_req = 1'b1; rd_sel = 2'd0;
      cycle();
      idle_inputs();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_state", 64'(state), 0);
      chk("arst_done", 64'(done), 0);
      chk("arst_valid", 64'(rd_valid), 0);
      chk("arst_data", 64'(rd_data), 0);
      chk("arst_sat_data", 64'(s_rd_data), 0);
      model_reset();
      #3;
      rst = 1'b1;
      repeat (3) cycle();
      chk("arst_idle", 64'(state), 0);

      // Saturation on the 4-bit unbounded instance
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      start = 1'b1; retire = 1'b1;
      repeat (20) cycle();
      idle_inputs();
      rd_req = 1'b1;
      rd_sel = 2'd0; cycle(); chk("sat_cycle", 64'(s_rd_data), 15);
      rd_sel = 2'd3; cycle(); chk("sat_retire", 64'(s_rd_data), 15);
      rd_sel = 2'd1; cycle(); chk("sat_stall", 64'(s_rd_data), 0);
      chk("sat_valid", 64'(s_rd_valid), 1);
      chk("sat_state", 64'(s_state), 1);
      chk("sat_done", 64'(s_done), 0);
      idle_inputs();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
